// File: rtl/reg_sb_pkg.sv
// Shared types and constants for the issue-side register scoreboard.
package reg_sb_pkg;

   localparam int unsigned SB_CNT_WIDTH = 2;
   localparam int unsigned NUM_GPR      = 32;
   localparam int unsigned SB_CNT_MAX   = (1 << SB_CNT_WIDTH) - 1;

   typedef logic [4:0]              regaddr_t;
   typedef logic [SB_CNT_WIDTH-1:0] sb_cnt_t;

   typedef struct packed {
      logic           valid;
      regaddr_t [1:0] src;
      regaddr_t       dst;
      logic           dst_en;
   } issue_slot_t;

endpackage

// File: rtl/reg_sb_counter.sv
// Pending-write counter for one architectural register; clamps at zero on over-retire.
module reg_sb_counter #(
   parameter int unsigned CNT_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           inc,
   input  logic [1:0]           dec,
   input  logic                 flush,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 busy,
   output logic                 underflow
);

   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH:0]   sum, dec_w;

   always_comb begin
      sum       = {1'b0, count_q} + (CNT_WIDTH+1)'(inc);
      dec_w     = (CNT_WIDTH+1)'(dec);
      // Retires in a flush cycle are discarded, so they cannot underflow.
      underflow = !flush && (dec_w > sum);
      count_d   = underflow ? '0 : CNT_WIDTH'(sum - dec_w);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (flush) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign busy  = (count_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// 2-wide in-order issue scoreboard: gates issue on RAW/WAW hazards, retires on writeback.
module reg_scoreboard
   import reg_sb_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = SB_CNT_WIDTH,
   parameter int unsigned NUM_SLOT  = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_SLOT-1:0]                issue_valid_i,
   input  logic [NUM_SLOT-1:0][1:0][4:0]      issue_src_i,
   input  logic [NUM_SLOT-1:0][4:0]           issue_dst_i,
   input  logic [NUM_SLOT-1:0]                issue_dst_en_i,
   output logic [NUM_SLOT-1:0]                issue_ready_o,
   input  logic [1:0]                         wb_en_i,
   input  logic [1:0][4:0]                    wb_addr_i,
   input  logic                               flush_i,
   output logic [NUM_GPR-1:0]                 busy_o,
   output logic                               err_o
);

   localparam logic [CNT_WIDTH-1:0] CntMax = '1;

   issue_slot_t          slot [NUM_SLOT];
   logic [CNT_WIDTH-1:0] cnt [NUM_GPR];
   logic [NUM_GPR-1:0]   underflow;
   logic [NUM_SLOT-1:0]  fire, src_free;
   logic                 same_dst, sat0, sat1, raw1;
   logic [CNT_WIDTH:0]   pend1;
   logic                 err_q;

   always_comb begin
      for (int k = 0; k < NUM_SLOT; k++) begin
         slot[k].valid  = issue_valid_i[k];
         slot[k].src    = issue_src_i[k];
         slot[k].dst    = issue_dst_i[k];
         slot[k].dst_en = issue_dst_en_i[k];
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_SLOT; k++) begin
         src_free[k] = 1'b1;
         for (int j = 0; j < 2; j++) begin
            if (slot[k].src[j] != '0 && cnt[slot[k].src[j]] != '0) src_free[k] = 1'b0;
         end
      end
      raw1 = 1'b0;
      for (int j = 0; j < 2; j++) begin
         if (slot[0].dst_en && slot[1].src[j] != '0 && slot[1].src[j] == slot[0].dst) raw1 = 1'b1;
      end
      sat0     = slot[0].dst_en && slot[0].dst != '0 && cnt[slot[0].dst] == CntMax;
      // Slot 1 sees the increment slot 0 is about to add to the same register.
      same_dst = slot[0].dst_en && slot[1].dst == slot[0].dst;
      pend1    = {1'b0, cnt[slot[1].dst]} + {{CNT_WIDTH{1'b0}}, same_dst};
      sat1     = slot[1].dst_en && slot[1].dst != '0 && pend1 >= {1'b0, CntMax};

      issue_ready_o[0] = !flush_i && src_free[0] && !sat0;
      fire[0]          = slot[0].valid && issue_ready_o[0];
      issue_ready_o[1] = fire[0] && !flush_i && src_free[1] && !sat1 && !raw1;
      fire[1]          = slot[1].valid && issue_ready_o[1];
   end

   assign cnt[0]       = '0;
   assign busy_o[0]    = 1'b0;
   assign underflow[0] = 1'b0;

   for (genvar r = 1; r < NUM_GPR; r++) begin : g_cnt
      logic [1:0] inc, dec;

      always_comb begin
         inc = '0;
         dec = '0;
         for (int k = 0; k < 2; k++) begin
            if (fire[k] && slot[k].dst_en && slot[k].dst == regaddr_t'(r)) inc = inc + 2'd1;
            if (wb_en_i[k] && wb_addr_i[k] == regaddr_t'(r)) dec = dec + 2'd1;
         end
      end

      reg_sb_counter #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
         .clk       (clk),
         .rst_n     (rst_n),
         .inc       (inc),
         .dec       (dec),
         .flush     (flush_i),
         .count     (cnt[r]),
         .busy      (busy_o[r]),
         .underflow (underflow[r])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (|underflow) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against a counter-array reference model.
module tb_reg_scoreboard;
   import reg_sb_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [1:0]           issue_valid_i;
   logic [1:0][1:0][4:0] issue_src_i;
   logic [1:0][4:0]      issue_dst_i;
   logic [1:0]           issue_dst_en_i;
   logic [1:0]           issue_ready_o;
   logic [1:0]           wb_en_i;
   logic [1:0][4:0]      wb_addr_i;
   logic                 flush_i;
   logic [31:0]          busy_o;
   logic                 err_o;

   int         cnt_m [32];
   bit         err_m;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [1:0] last_ready;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .issue_valid_i  (issue_valid_i),
      .issue_src_i    (issue_src_i),
      .issue_dst_i    (issue_dst_i),
      .issue_dst_en_i (issue_dst_en_i),
      .issue_ready_o  (issue_ready_o),
      .wb_en_i        (wb_en_i),
      .wb_addr_i      (wb_addr_i),
      .flush_i        (flush_i),
      .busy_o         (busy_o),
      .err_o          (err_o)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit srcs_free(int k);
      for (int j = 0; j < 2; j++) begin
         if (issue_src_i[k][j] != 0 && cnt_m[issue_src_i[k][j]] != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Ready as the hazard rules state it, evaluated on the model's counters.
   function automatic logic [1:0] model_ready();
      logic [1:0] rdy;
      int         d0, d1, extra;
      bit         raw;
      d0  = issue_dst_i[0];
      d1  = issue_dst_i[1];
      rdy = 2'b00;
      if (!flush_i && srcs_free(0) && !(issue_dst_en_i[0] && d0 != 0 && cnt_m[d0] >= SB_CNT_MAX))
         rdy[0] = 1'b1;
      raw = 1'b0;
      for (int j = 0; j < 2; j++) begin
         if (issue_dst_en_i[0] && issue_src_i[1][j] != 0 && issue_src_i[1][j] == d0) raw = 1'b1;
      end
      extra = (issue_dst_en_i[0] && d0 == d1) ? 1 : 0;
      if (issue_valid_i[0] && rdy[0] && !flush_i && srcs_free(1) && !raw &&
          !(issue_dst_en_i[1] && d1 != 0 && cnt_m[d1] + extra >= SB_CNT_MAX))
         rdy[1] = 1'b1;
      return rdy;
   endfunction

   task automatic cycle();
      logic [1:0]  er;
      logic [31:0] eb;
      int          v;
      #2;
      er         = model_ready();
      last_ready = issue_ready_o;
      if (rst_n) check("ready", {30'd0, issue_ready_o}, {30'd0, er});
      if (!rst_n) begin
         foreach (cnt_m[r]) cnt_m[r] = 0;
         err_m = 1'b0;
      end else if (flush_i) begin
         foreach (cnt_m[r]) cnt_m[r] = 0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            v = cnt_m[r];
            for (int k = 0; k < 2; k++) begin
               if (issue_valid_i[k] && er[k] && issue_dst_en_i[k] && issue_dst_i[k] == r) v++;
               if (wb_en_i[k] && wb_addr_i[k] == r) v--;
            end
            if (v < 0) begin
               v     = 0;
               err_m = 1'b1;
            end
            cnt_m[r] = v;
         end
      end
      @(posedge clk);
      #1;
      eb = '0;
      for (int r = 1; r < 32; r++) eb[r] = (cnt_m[r] != 0);
      check("busy", busy_o, eb);
      check("err", {31'd0, err_o}, {31'd0, err_m});
   endtask

   task automatic idle();
      rst_n          = 1'b1;
      flush_i        = 1'b0;
      issue_valid_i  = '0;
      issue_src_i    = '0;
      issue_dst_i    = '0;
      issue_dst_en_i = '0;
      wb_en_i        = '0;
      wb_addr_i      = '0;
   endtask

   task automatic slot(int k, int s0, int s1, int d, bit de);
      issue_valid_i[k]  = 1'b1;
      issue_src_i[k][0] = 5'(s0);
      issue_src_i[k][1] = 5'(s1);
      issue_dst_i[k]    = 5'(d);
      issue_dst_en_i[k] = de;
   endtask

   task automatic wb(int k, int a);
      wb_en_i[k]   = 1'b1;
      wb_addr_i[k] = 5'(a);
   endtask

   task automatic do_flush();
      idle();
      flush_i = 1'b1;
      cycle();
   endtask

   initial begin
      foreach (cnt_m[r]) cnt_m[r] = 0;
      err_m = 1'b0;
      idle();
      rst_n = 1'b0;
      cycle();
      cycle();

      // Independent bundle issues fully.
      idle(); slot(0, 3, 4, 5, 1); slot(1, 6, 8, 11, 1); cycle();
      check("t1_ready", {30'd0, last_ready}, 32'd3);
      check("t1_busy5", {31'd0, busy_o[5]}, 32'd1);

      // RAW stall, no same-cycle writeback bypass.
      idle(); slot(0, 0, 0, 7, 1); cycle();
      idle(); slot(0, 7, 0, 0, 0); wb(0, 7); cycle();
      check("t2_stall", {31'd0, last_ready[0]}, 32'd0);
      check("t2_busy7", {31'd0, busy_o[7]}, 32'd0);
      idle(); slot(0, 7, 0, 0, 0); cycle();
      check("t2_unblock", {31'd0, last_ready[0]}, 32'd1);

      // Intra-bundle RAW and in-order gating.
      idle(); slot(0, 0, 0, 9, 1); slot(1, 9, 0, 13, 1); cycle();
      check("t3_intra", {30'd0, last_ready}, 32'd1);
      idle(); slot(0, 0, 0, 2, 1); cycle();
      idle(); slot(0, 2, 0, 14, 1); slot(1, 15, 16, 17, 1); cycle();
      check("t3_inorder", {30'd0, last_ready}, 32'd0);

      // WAW saturation on r10.
      do_flush();
      repeat (3) begin
         idle(); slot(0, 0, 0, 10, 1); cycle();
      end
      idle(); slot(0, 0, 0, 10, 1); wb(0, 10); cycle();
      check("t4_sat", {31'd0, last_ready[0]}, 32'd0);
      idle(); slot(0, 0, 0, 10, 1); slot(1, 0, 0, 10, 1); cycle();
      check("t4_dual", {30'd0, last_ready}, 32'd1);

      // Net inc/dec, then over-retire.
      do_flush();
      idle(); slot(0, 0, 0, 12, 1); cycle();
      idle(); slot(0, 0, 0, 12, 1); wb(0, 12); wb(1, 12); cycle();
      check("t5_fire", {31'd0, last_ready[0]}, 32'd1);
      check("t5_noerr", {31'd0, err_o}, 32'd0);
      idle(); wb(0, 12); cycle();
      check("t5_err", {31'd0, err_o}, 32'd1);
      check("t5_busy12", {31'd0, busy_o[12]}, 32'd0);

      // Load every register, then flush with concurrent issue.
      for (int r = 1; r < 32; r += 2) begin
         idle(); slot(0, 0, 0, r, 1);
         if (r < 31) slot(1, 0, 0, r + 1, 1);
         cycle();
      end
      check("t6_loaded", busy_o, 32'hFFFF_FFFE);
      idle(); flush_i = 1'b1; slot(0, 0, 0, 5, 1); slot(1, 0, 0, 6, 1); wb(0, 3); cycle();
      check("t6_flush_rdy", {30'd0, last_ready}, 32'd0);
      check("t6_flush_busy", busy_o, 32'd0);
      check("t6_err_kept", {31'd0, err_o}, 32'd1);
      idle(); slot(0, 0, 0, 0, 1); slot(1, 0, 0, 0, 1); wb(0, 0); wb(1, 0); cycle();
      check("t6_r0_rdy", {30'd0, last_ready}, 32'd3);
      check("t6_r0_busy", busy_o, 32'd0);
      idle(); slot(0, 0, 0, 20, 1); cycle();
      idle(); rst_n = 1'b0; slot(0, 0, 0, 21, 1); wb(0, 4); cycle();
      check("t6_rst_busy", busy_o, 32'd0);
      check("t6_rst_err", {31'd0, err_o}, 32'd0);

      // Random traffic on a small register pool to provoke hazards.
      for (int i = 0; i < 3000; i++) begin
         idle();
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 9) < 8)
               slot(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) < 35) wb(k, $urandom_range(0, 7));
         end
         if ($urandom_range(0, 49) == 0) flush_i = 1'b1;
         if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-side scoreboard for the 4-read/2-write general register file.
- Tracks in-flight writes per architectural register and gates a 2-wide in-order issue bundle on RAW/WAW hazards.
- Writeback ports that feed the register file write ports retire pending writes.
- Sits between the decode/issue stage and the register file read; the register file itself is unchanged.

Parameters:
- CNT_WIDTH, 2, width of per-register pending-write counter; max in-flight writes per register = 2^CNT_WIDTH-1.
- NUM_SLOT, 2, issue slots per cycle; fixed at 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- issue_valid_i  in  2  slot k holds a valid instruction
- issue_src_i  in  2x2x5  per slot, two source register addresses; address 0 means no dependency
- issue_dst_i  in  2x5  per slot, destination register address
- issue_dst_en_i  in  2  per slot, instruction writes issue_dst_i
- issue_ready_o  out  2  per slot, may issue this cycle (combinational)
- wb_en_i  in  2  writeback port k retires one write; mirrors the register file write enable
- wb_addr_i  in  2x5  writeback register address
- flush_i  in  1  pipeline flush; discard all pending state
- busy_o  out  32  registered; bit r = counter[r] != 0; bit 0 always 0
- err_o  out  1  sticky; set on retire to a register with counter 0

Behaviour:
- Reset (rst_n=0 at posedge clk): all counters 0, busy_o=0, err_o=0. Reset overrides flush, issue and wb in the same cycle.
- State is 31 counters (r1..r31). Register 0 is never tracked:
  - Issue or wb to r0 has no effect.
  - A source of r0 never stalls.
- Fire rule: slot k fires when issue_valid_i[k] && issue_ready_o[k]. Counter updates are visible the following cycle.
- issue_ready_o[0] = !flush_i, and:
  - neither nonzero source has counter != 0;
  - if issue_dst_en_i[0] and dst != 0, counter[dst] is not saturated.
- issue_ready_o[1] = slot-0 conditions evaluated on slot-1 operands, AND:
  - slot 0 fires (in-order; slot 1 never issues alone);
  - no intra-bundle RAW: slot-1 nonzero src != slot-0 dst when issue_dst_en_i[0];
  - saturation is checked against counter + (slot-0 increment) when both slots target the same dst.
- Ready is computed from registered counters only. There is no same-cycle wb bypass: a register retired in cycle N unblocks issue in cycle N+1.
- Counter next value = cur + inc - dec, where:
  - inc = number of fired slots with dst_en targeting r (0..2);
  - dec = number of wb ports targeting r (0..2);
  - simultaneous inc and dec on the same register apply net.
- dec greater than cur + inc: the counter clamps at 0 and err_o is set. err_o clears only on reset.
- Saturation can never be exceeded because issue is gated.
- flush_i=1: next cycle all counters 0 and busy_o=0. Issue and wb in the flush cycle are ignored (ready forced 0). err_o is kept.
- busy_o is derived from counter registers, so it reflects the post-update state one cycle after fire/wb.

Decomposition:
- Package reg_sb_pkg holds:
  - typedef regaddr_t (5 bits);
  - typedef sb_cnt_t (CNT_WIDTH bits);
  - localparam NUM_GPR = 32;
  - localparam SB_CNT_MAX = 2^CNT_WIDTH-1;
  - typedef issue_slot_t {valid, src[2], dst, dst_en}.
- Sub-module reg_sb_counter is instantiated per register r1..r31. It takes:
  - inc count (2 bits);
  - dec count (2 bits);
  - flush;
  - outputs count, busy and an underflow pulse.
- The top OR-reduces the underflow pulses into err_o.

Test Plan:
- Reset then idle: busy_o=0, err_o=0; slot0 src={r3,r4}, dst r5 -> issue_ready_o=2'b11 with slot1 independent; next cycle busy_o[5]=1.
- RAW stall: issue dst r7 in cycle 0; cycle 1 slot0 src r7 -> ready[0]=0. wb r7 in cycle 1 -> ready[0] still 0 in cycle 1, 1 in cycle 2; busy_o[7]=0 in cycle 2.
- Intra-bundle: slot0 dst r9, slot1 src r9 -> ready=2'b01. Slot0 stalled on r2 busy -> ready[1]=0 even if slot1 is independent.
- WAW saturation (CNT_WIDTH=2): issue 3 writes to r10 with no wb -> counter=3; 4th issue blocked. Dual-slot both dst r10 at counter=2 -> ready=2'b01. Single wb r10 -> counter 2 next cycle.
- Simultaneous: counter[r12]=1; slot0 dst r12 fires while wb0 and wb1 both retire r12 -> counter 0, err_o=0. A further wb r12 at counter 0 -> err_o=1, counter stays 0.
- Flush and r0: counters r1..r31 loaded nonzero, flush_i=1 with concurrent issue -> ready=0, all busy_o=0 next cycle. Issue/wb to r0 and src r0 never stall and never touch busy_o[0]. Reset asserted mid-sequence -> all counters 0.
